// File: rtl/character_transmission_pkg.sv
// Shared UART-lite definitions: frame state encoding, frame length and
// parameter legality, common to the transmitter and the receiver.
package character_transmission_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int CHAR_W = 8;

  // Clocks per complete frame: start bit, data bits and one stop bit.
  function automatic int total_bits(input int oversampling, input int data_bits);
    return oversampling * (data_bits + 2);
  endfunction

  function automatic bit params_legal(input int oversampling, input int data_bits);
    return (oversampling >= 2) && (data_bits >= 1) && (data_bits <= CHAR_W);
  endfunction

endpackage

// File: rtl/character_transmission_if.sv
// Character handshake and serial-line bundle between a character source
// (master) and the UART-lite transmitter (slave).
interface character_transmission_if;
  import character_transmission_pkg::*;

  logic [CHAR_W-1:0] char_i;
  logic              valid_i;
  logic              ready_o;
  logic              tx_o;
  logic              busy_o;

  modport master (
    output char_i,
    output valid_i,
    input  ready_o,
    input  tx_o,
    input  busy_o
  );

  modport slave (
    input  char_i,
    input  valid_i,
    output ready_o,
    output tx_o,
    output busy_o
  );

endinterface

// File: rtl/character_transmission_bit_timer.sv
// Serial bit timer: down-counts OVERSAMPLING clocks per bit and strobes
// o_bit_done on the last sample cycle of every bit while enabled.
module character_transmission_bit_timer
#(
  parameter int OVERSAMPLING = 17
)
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_bit_done
);

  localparam int CNT_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OVERSAMPLING - 1);

  if (OVERSAMPLING < 2) begin : g_bad_oversampling
    $error("character_transmission_bit_timer: OVERSAMPLING must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_terminal;

  assign w_terminal = (r_cnt == '0);
  assign o_bit_done = i_enable && w_terminal;

  // Reloads itself at terminal count so consecutive bits need no restart.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= CNT_LOAD;
    end else if (i_enable) begin
      if (w_terminal) begin
        r_cnt <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/character_transmission.sv
// UART-lite transmitter: accepts characters on a valid/ready handshake and
// sends start, DATA_BITS data (LSB first) and stop bits on tx_o.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | line idle high, waiting for a character
//   ST_START | start bit (low) for OVERSAMPLING clocks
//   ST_DATA  | data bits, shifter[0] on the line, LSB first
//   ST_STOP  | stop bit (high); frame end picks up the next character
module character_transmission
  import character_transmission_pkg::*;
#(
  parameter int OVERSAMPLING = 17,
  parameter int DATA_BITS    = 7
)
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  character_transmission_if.slave  bus
);

  localparam int TOTAL_BITS = total_bits(OVERSAMPLING, DATA_BITS);
  localparam int BIT_W      = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  if (!params_legal(OVERSAMPLING, DATA_BITS)) begin : g_bad_params
    $error("character_transmission: illegal OVERSAMPLING/DATA_BITS");
  end

  uart_state_t            r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_hold;
  logic                   r_hold_full;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_tx;
  logic                   r_ready;
  logic                   r_busy;

  logic                   w_xfer;
  logic                   w_bit_done;
  logic                   w_frame_end;
  logic                   w_hold_load;
  logic [DATA_BITS-1:0]   w_char;

  assign w_char      = bus.char_i[DATA_BITS-1:0];
  assign w_xfer      = bus.valid_i && r_ready;
  assign w_frame_end = (r_state == ST_STOP) && w_bit_done;
  // Mid-frame arrivals park in the holding register; at frame end they go
  // straight to the shifter instead, keeping frames gapless.
  assign w_hold_load = w_xfer && (r_state != ST_IDLE) && !w_frame_end;

  character_transmission_bit_timer #(
    .OVERSAMPLING (OVERSAMPLING)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_restart  (w_xfer && (r_state == ST_IDLE)),
    .i_enable   (r_state != ST_IDLE),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx        <= 1'b1;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_shift <= w_char;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_ready     <= 1'b1;
              r_tx        <= 1'b0;
              r_state     <= ST_START;
            end else if (w_xfer) begin
              r_shift <= w_char;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_hold_load) begin
        r_hold      <= w_char;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end
    end
  end

  assign bus.tx_o    = r_tx;
  assign bus.ready_o = r_ready;
  assign bus.busy_o  = r_busy;

endmodule

// File: tb/tb_character_transmission.sv
// Directed bench for the UART-lite transmitter: frame shape, handshake
// back-pressure, gapless chaining and mid-frame reset.
module tb_character_transmission;

  localparam int OS    = 17;
  localparam int DB    = 7;
  localparam int TOTAL = OS * (DB + 2);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  character_transmission_if bus ();

  character_transmission #(
    .OVERSAMPLING (OS),
    .DATA_BITS    (DB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},    0, bus.tx_o,    1'b1);
    chk({tag, "_ready"}, 0, bus.ready_o, 1'b1);
    chk({tag, "_busy"},  0, bus.busy_o,  1'b0);
  endtask

  // Walks one frame cycle by cycle (k=1 is the cycle after the edge that
  // started it). ready_o is expected low for k in [rlo,rhi]; the sender
  // inputs are re-driven at cycles ka and kb after sampling.
  task automatic run_frame(input string tag, input logic [7:0] exp_ch,
                           input int rlo, input int rhi,
                           input int ka, input logic va, input logic [7:0] ca,
                           input int kb, input logic vb, input logic [7:0] cb);
    int   bi;
    logic exp_tx;
    for (int k = 1; k <= TOTAL; k++) begin
      @(negedge clk);
      bi = (k - 1) / OS;
      if (bi == 0)       exp_tx = 1'b0;
      else if (bi <= DB) exp_tx = exp_ch[bi-1];
      else               exp_tx = 1'b1;
      chk({tag, "_tx"},    k, bus.tx_o,    exp_tx);
      chk({tag, "_busy"},  k, bus.busy_o,  1'b1);
      chk({tag, "_ready"}, k, bus.ready_o, (k >= rlo && k <= rhi) ? 1'b0 : 1'b1);
      if (k == ka) begin bus.valid_i = va; bus.char_i = ca; end
      if (k == kb) begin bus.valid_i = vb; bus.char_i = cb; end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.char_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // Single frame of 0x55
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h55;
    run_frame("t1", 8'h55, 1, 0, 1, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_idle("t1_end");

    // 0x00, then 0x7F one cycle later, then 0x33 held off until ready
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h00;
    run_frame("t2a", 8'h00, 2, TOTAL, 1, 1'b1, 8'h7F, 2, 1'b1, 8'h33);
    run_frame("t2b", 8'h7F, 2, TOTAL, 2, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    run_frame("t2c", 8'h33, 1, 0, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_idle("t2_end");

    // Bit 7 of char_i is not transmitted
    bus.valid_i = 1'b1;
    bus.char_i  = 8'hC1;
    run_frame("t3", 8'h41, 1, 0, 1, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_idle("t3_end");

    // Transfer on the frame-end edge with the holding register empty
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h2D;
    run_frame("t6a", 8'h2D, 1, 0, 1, 1'b0, 8'h00, TOTAL, 1'b1, 8'h12);
    run_frame("t6b", 8'h12, 1, 0, 1, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_idle("t6_end");

    // Reset at cycle 40 of a frame with a character waiting in the holding register
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h66;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.valid_i = 1'b0;
      if (k == 2) begin bus.valid_i = 1'b1; bus.char_i = 8'h5A; end
      if (k == 3) bus.valid_i = 1'b0;
      if (k == 39) begin
        chk("t4_tx_bit1",  k, bus.tx_o,    1'b1);
        chk("t4_ready",    k, bus.ready_o, 1'b0);
        chk("t4_busy",     k, bus.busy_o,  1'b1);
      end
      if (k == 40) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk_idle("t4_after_rst");
    for (int k = 1; k <= 2 * OS; k++) begin
      @(negedge clk);
      chk("t4_quiet_tx",   k, bus.tx_o,   1'b1);
      chk("t4_quiet_busy", k, bus.busy_o, 1'b0);
    end
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h2A;
    run_frame("t4", 8'h2A, 1, 0, 1, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_idle("t4_end");

    // All 128 codes back-to-back through the holding register
    bus.valid_i = 1'b1;
    bus.char_i  = 8'h00;
    for (int v = 0; v < 128; v++) begin
      if (v < 127)
        run_frame("t5", 8'(v), 2, TOTAL, 1, 1'b1, 8'(v + 1), 2, 1'b0, 8'h00);
      else
        run_frame("t5", 8'(v), 1, 0, 1, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    end
    @(negedge clk);
    chk_idle("t5_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/character_transmission.md
Name: character_transmission

Overview:
UART-lite transmitter. It is the transmit-side counterpart of character_recovery.
- Accepts characters over a valid/ready handshake.
- Serialises each one as an asynchronous frame on tx_o: start bit, DATA_BITS data bits LSB first, one stop bit.
- Each bit is held for OVERSAMPLING clocks, so frames are bit-compatible with character_recovery at the same parameters.
- A one-entry holding register allows gapless back-to-back frames.

Parameters:
- OVERSAMPLING, 17, clocks per serial bit; must be >= 2.
- DATA_BITS, 7, data bits per frame; range 1..8.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- char_i  input  8  character to send; only bits [DATA_BITS-1:0] are used, upper bits ignored.
- valid_i  input  1  char_i is valid.
- ready_o  output  1  block can accept a character this cycle (holding register empty).
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  frame in progress or holding register occupied.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- All outputs are registered. Reset values: tx_o=1, ready_o=1, busy_o=0. State=IDLE; holding register empty; counters cleared.
- Localparam TOTAL_BITS = OVERSAMPLING*(DATA_BITS+2).
- Transfer: occurs at a rising edge where valid_i && ready_o && !rst_i.
- States: IDLE, START, DATA, STOP.
  - A sample counter counts 0..OVERSAMPLING-1.
  - A bit counter counts 0..DATA_BITS-1 in DATA.
- IDLE:
  - tx_o=1.
  - On a transfer: load the shifter with char_i[DATA_BITS-1:0], go to START, tx_o<=0 at that same edge.
- START: tx_o=0 for OVERSAMPLING cycles, then go to DATA.
- DATA:
  - tx_o = shifter[0] for OVERSAMPLING cycles per bit, then shift right.
  - After DATA_BITS bits, go to STOP.
- STOP: tx_o=1 for OVERSAMPLING cycles. On the last STOP cycle (frame-end edge):
  - if the holding register is full, move it into the shifter, clear the holding register, go to START, tx_o<=0;
  - else if a transfer occurs on this edge, load char_i directly into the shifter, go to START;
  - else go to IDLE.
- Frame timing:
  - tx_o low is first visible in the cycle after the accepting edge.
  - Frame length is exactly TOTAL_BITS cycles.
  - Consecutive start-bit falling edges are exactly TOTAL_BITS cycles apart when the holding register is pre-filled.
- Transfer while not in IDLE, and not at the frame-end edge of STOP: char_i goes to the holding register; ready_o<=0 at that edge.
- ready_o = holding register empty. A transfer is never accepted while it is full, so a new load and a drain never coincide.
- busy_o <= (next state != IDLE) || holding register full. busy_o falls at the frame-end edge when nothing is pending.
- valid_i with ready_o=0: ignored; the sender must hold valid_i. char_i changing without a transfer has no effect.
- Reset mid-frame:
  - the frame is aborted immediately;
  - tx_o=1 from the next cycle;
  - holding register discarded, ready_o=1, busy_o=0.
  - The truncated frame may produce a frame error at the far end; this is acceptable.
- Counter widths: sample counter $clog2(OVERSAMPLING), bit counter $clog2(DATA_BITS+1). No wrap beyond the terminal counts.

Decomposition:
- Shared include (uart_lite constants):
  - state encodings (IDLE/START/DATA/STOP);
  - TOTAL_BITS derivation;
  - the parameter legality checks, also used by character_recovery.
- One natural sub-module: bit_timer.
  - Parameterised on OVERSAMPLING.
  - Inputs: restart and enable.
  - Output: a one-cycle bit_done strobe on the last sample cycle.
  - Reusable by the receiver.

Test Plan (OVERSAMPLING=17, DATA_BITS=7):
1. Reset, then a single transfer of 0x55 at edge N.
   - tx_o: 0 for cycles N+1..N+17, then 1,0,1,0,1,0,1 for 17 cycles each, then 1 for 17 cycles.
   - busy_o falls at edge N+153. ready_o stays 1 throughout.
2. Transfer 0x00, then 0x7F one cycle later.
   - ready_o=0 from the second edge until the first frame ends.
   - The second start bit begins exactly 153 cycles after the first.
   - A third valid_i is held off until ready_o=1.
3. char_i=0xC1 → frame carries 0x41; bit 7 is ignored.
4. Assert rst_i for 1 cycle at cycle 40 of a frame.
   - tx_o=1, ready_o=1, busy_o=0 on the next cycle.
   - A following transfer of 0x2A produces a clean frame.
5. Loopback tx_o→character_recovery rx_i, sending all 128 values back-to-back.
   - Each valid_o carries the matching char_o.
   - frame_error_o never asserted.
   - valid_o pulses exactly 153 cycles apart.
6. Transfer on the frame-end edge with the holding register empty → next start bit begins with no idle cycle; ready_o stays 1.
